mem_sram_ctrl: RTL

//  Responder side of the MEM-stage data-memory interface: services the load/store

---
 rtl/mem_sram_if.sv | 22 ++
 rtl/mem_sram_ctrl.sv | 77 +++++++
 2 files changed

// File: rtl/mem_sram_if.sv
// mem_sram_if: MEM-stage load/store request bus plus the external 16-bit SRAM pins.
interface mem_sram_if #(parameter int ADDR_W = 18);
  logic              rd_en;
  logic              wr_en;
  logic [31:0]       address;
  logic [31:0]       write_data;
  logic [31:0]       read_data;
  logic              ready;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_dq_out;
  logic              sram_dq_oe;
  logic [15:0]       sram_dq_in;
  logic              sram_we_n;
  modport master (
    output rd_en, wr_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
  modport slave (
    input  rd_en, wr_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl: services 32-bit MEM-stage loads/stores as two half-word accesses
// to an asynchronous 16-bit SRAM, holding ready low while an access is in flight.
module mem_sram_ctrl #(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 1,
  parameter int BASE_ADDR   = 1024
) (
  input logic       clk,
  input logic       rst,
  mem_sram_if.slave bus
);
  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam int WW = ADDR_W - 1;
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [WW-1:0]     word_q, word_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       dq_q, dq_d;
  logic              oe_q, oe_d;
  logic              we_n_q, we_n_d;
  logic              req, last, capture, active_d;
  assign req  = bus.rd_en | bus.wr_en;
  assign last = cnt_q == CW'(WAIT_CYCLES - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      dq_q    <= '0;
      oe_q    <= 1'b0;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      dq_q    <= dq_d;
      oe_q    <= oe_d;
      we_n_q  <= we_n_d;
    end
  end
  // SRAM pins are computed from the next state so they are registered yet line up with LO/HI
  always_comb begin
    state_d  = state_q == IDLE ? (req ? LO : IDLE) :
               state_q == LO   ? (last ? HI : LO) :
               state_q == HI   ? (last ? DONE : HI) : IDLE;
    cnt_d    = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + CW'(1);
    capture  = state_q == IDLE && req;
    wr_d     = capture ? bus.wr_en : wr_q;
    word_d   = capture ? WW'((bus.address - 32'(BASE_ADDR)) >> 2) : word_q;
    wdata_d  = capture ? bus.write_data : wdata_q;
    active_d = state_d == LO || state_d == HI;
    addr_d   = active_d ? {word_d, state_d == HI} : addr_q;
    dq_d     = state_d == HI ? wdata_d[31:16] : state_d == LO ? wdata_d[15:0] : dq_q;
    oe_d     = active_d && wr_d;
    we_n_d   = !oe_d;
    rdata_d  = {(state_q == HI && last && !wr_q) ? bus.sram_dq_in : rdata_q[31:16],
                (state_q == LO && last && !wr_q) ? bus.sram_dq_in : rdata_q[15:0]};
  end
  assign bus.ready       = (state_q == IDLE && !req) || state_q == DONE;
  assign bus.read_data   = rdata_q;
  assign bus.sram_addr   = addr_q;
  assign bus.sram_dq_out = dq_q;
  assign bus.sram_dq_oe  = oe_q;
  assign bus.sram_we_n   = we_n_q;
endmodule
